// File: rtl/led_strip_pkg.sv
//==============================================================================
// Module      : led_strip_pkg
// Description : Shared types, constants and helpers for the SK9822 LED-strip
//               frame scheduler.
//               - sk9822_word_t : one 32-bit word on the strip
//               - START_WORD / END_WORD / HDR : framing constants
//               - n_end_words() : number of end-frame words for a strip length
//               - sched_state_t : frame scheduler FSM states
//               - bri_cap()     : min() of a 5-bit brightness and a cap
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package led_strip_pkg;

  typedef logic [31:0] sk9822_word_t;

  localparam sk9822_word_t START_WORD = 32'h0000_0000;
  localparam sk9822_word_t END_WORD   = 32'h0000_0000;
  localparam logic [2:0]   HDR        = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    LEDS  = 2'd2,
    END   = 2'd3
  } sched_state_t;

  // The end frame must supply at least n_leds/2 extra clock edges so the
  // last LED's data propagates through the chain; one word per 64 LEDs plus
  // one spare covers that.
  function automatic int n_end_words(input int n_leds);
    return 1 + (n_leds + 63) / 64;
  endfunction

  function automatic logic [4:0] bri_cap(input logic [4:0] bri, input logic [4:0] cap);
    return (bri < cap) ? bri : cap;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_rr_arbiter.sv
//==============================================================================
// Module      : led_rr_arbiter
// Description : Round-robin requester selection. Picks the first active
//               request at or after rr_ptr+1 (mod N_REQ) and, when upd_i is
//               high and a request exists, moves rr_ptr to the winner.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset (rr_ptr = N_REQ-1)
//               req_i    - per-requester request levels
//               upd_i    - commit the current selection to the pointer
//               grant_o  - one-hot selection (combinational, all-zero if none)
//               any_o    - at least one request is active
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             upd_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             any_o
);

  localparam int              PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Scan N_REQ candidates starting just after the last winner; the last
  // candidate visited is the previous winner itself.
  always_comb begin
    sel_idx = rr_ptr_q;
    cand    = '0;
    found   = 1'b0;
    grant_o = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_i[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
    if (found) begin
      grant_o[sel_idx] = 1'b1;
    end
    any_o    = found;
    rr_ptr_d = (upd_i && found) ? sel_idx : rr_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= PTR_RST;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_strip_frame_scheduler.sv
//==============================================================================
// Module      : led_strip_frame_scheduler
// Description : Refresh-tick driven SK9822 frame sequencer shared between
//               N_REQ frame sources. Each frame is START_WORD, N_LEDS LED
//               words from the granted source, then n_end_words() END_WORDs,
//               streamed back-to-back over a registered valid/ready port.
//               Optional build macro LED_SCHED_GLOBAL_DIM_EN caps each LED
//               word's brightness field [28:24] at 'dim'.
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               req        - per-requester frame request (level)
//               grant      - one-hot grant, frozen for the whole frame
//               word_idx   - LED index the next load edge will consume
//               rq_word    - per-requester LED word for word_idx
//               dim        - global brightness cap (macro builds only)
//               ser_word   - word to the serializer
//               ser_valid  - ser_word valid
//               ser_ready  - serializer accepts
//               frame_done - one-cycle pulse after the last end word
//               overrun    - sticky: tick while a tick was already pending
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module led_strip_frame_scheduler
  import led_strip_pkg::*;
#(
  parameter  int CLK_MHZ    = 33,
  parameter  int REFRESH_HZ = 60,
  parameter  int N_LEDS     = 13,
  parameter  int N_REQ      = 2,
  localparam int IDX_W      = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       grant,
  output logic [IDX_W-1:0]       word_idx,
  input  logic [N_REQ-1:0][31:0] rq_word,
  input  logic [4:0]             dim,
  output logic [31:0]            ser_word,
  output logic                   ser_valid,
  input  logic                   ser_ready,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int               PERIOD_CYCLES = CLK_MHZ * 1_000_000 / REFRESH_HZ;
  localparam int               TMR_W         = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(PERIOD_CYCLES - 1);
  localparam int               N_END         = n_end_words(N_LEDS);
  localparam int               END_W         = $clog2(N_END + 1);
  localparam logic [END_W-1:0] END_LAST      = END_W'(N_END - 1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(N_LEDS - 1);

  sched_state_t     state_q,   state_d;
  logic [TMR_W-1:0] tmr_q;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [N_REQ-1:0] grant_q,   grant_d;
  sk9822_word_t     word_q,    word_d;
  logic             valid_q,   valid_d;
  logic [IDX_W-1:0] led_q,     led_d;     // LED index currently on ser_word
  logic [END_W-1:0] end_q,     end_d;     // end words already accepted
  logic             done_q,    done_d;

  logic             tick;
  logic             accept;
  logic             arb_go;
  logic [N_REQ-1:0] arb_grant;
  logic             arb_any;
  sk9822_word_t     led_word;
  sk9822_word_t     load_word;

  assign tick   = (tmr_q == TMR_LAST);
  assign accept = valid_q && ser_ready;
  assign arb_go = (state_q == IDLE) && (tick || pending_q);

  led_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .upd_i   (arb_go),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  // The source for the next load is addressed combinationally: index 0
  // while the start word is out, then one ahead of the LED on the bus.
  always_comb begin
    word_idx = '0;
    if (state_q == LEDS && led_q != IDX_LAST) begin
      word_idx = led_q + 1'b1;
    end
  end

  always_comb begin
    led_word = '0;
    for (int r = 0; r < N_REQ; r++) begin
      led_word = led_word | (rq_word[r] & {32{grant_q[r]}});
    end
  end

`ifdef LED_SCHED_GLOBAL_DIM_EN
  assign load_word = {led_word[31:29], bri_cap(led_word[28:24], dim), led_word[23:0]};
`else
  logic unused_dim;
  assign unused_dim = ^dim;
  assign load_word  = led_word;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (tick) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    grant_d   = grant_q;
    word_d    = word_q;
    valid_d   = valid_q;
    led_d     = led_q;
    end_d     = end_q;
    done_d    = 1'b0;

    if (tick && pending_q) begin
      overrun_d = 1'b1;
    end
    // Ticks that land mid-frame are remembered; IDLE consumes them.
    if (tick && state_q != IDLE) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tick || pending_q) begin
          pending_d = 1'b0;
          if (arb_any) begin
            grant_d = arb_grant;
            word_d  = START_WORD;
            valid_d = 1'b1;
            state_d = START;
          end
        end
      end
      START: begin
        if (accept) begin
          word_d  = load_word;
          led_d   = '0;
          state_d = LEDS;
        end
      end
      LEDS: begin
        if (accept) begin
          if (led_q == IDX_LAST) begin
            word_d  = END_WORD;
            end_d   = '0;
            state_d = END;
          end else begin
            word_d = load_word;
            led_d  = led_q + 1'b1;
          end
        end
      end
      END: begin
        if (accept) begin
          if (end_q == END_LAST) begin
            valid_d = 1'b0;
            grant_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            end_d = end_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      grant_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      led_q     <= '0;
      end_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      grant_q   <= grant_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      led_q     <= led_d;
      end_q     <= end_d;
      done_q    <= done_d;
    end
  end

  assign grant      = grant_q;
  assign ser_word   = word_q;
  assign ser_valid  = valid_q;
  assign frame_done = done_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire
